// File: rtl/ballot_terminal_scheduler_pkg.sv
// Shared election types: phase encoding, mode codes, field widths
// and the packed core transaction bundle.
package election_pkg;

  typedef enum logic [1:0] {
    PH_IDLE     = 2'd0,
    PH_REGISTER = 2'd1,
    PH_VOTING   = 2'd2,
    PH_RESULTS  = 2'd3
  } phase_t;

  localparam int N_TERM_MAX = 4;
  localparam int MODE_W     = 2;
  localparam int USERID_W   = 6;
  localparam int CAND_W     = 2;
  localparam int TIMER_W    = 8;

  localparam logic [MODE_W-1:0] MODE_REG  = 2'd0;
  localparam logic [MODE_W-1:0] MODE_VOTE = 2'd1;

  typedef struct packed {
    logic [MODE_W-1:0]   mode;
    logic [USERID_W-1:0] user_id;
    logic [CAND_W-1:0]   cand;
  } txn_t;

  function automatic logic [1:0] ptr_after(
    input logic [1:0] w
  );
    return w + 2'd1;
  endfunction

endpackage

// File: rtl/ballot_terminal_scheduler_if.sv
// Terminal request bus and core transaction port of the scheduler.
// slave: scheduler side; master: terminals + core side.
interface ballot_terminal_scheduler_if;
  import election_pkg::*;

  logic                  start;
  logic [3:0]            req;
  logic [4*MODE_W-1:0]   mode_in;
  logic [4*USERID_W-1:0] userID_in;
  logic [4*CAND_W-1:0]   candidate_in;
  logic [3:0]            grant;
  logic                  core_valid;
  logic                  core_ready;
  logic [MODE_W-1:0]     core_mode;
  logic [USERID_W-1:0]   core_userID;
  logic [CAND_W-1:0]     core_candidate;
  logic [1:0]            phase;
  logic [TIMER_W-1:0]    cycles_left;
  logic                  results_valid;

  modport slave (
    input  start, req, mode_in,
    input  userID_in, candidate_in,
    input  core_ready,
    output grant, core_valid,
    output core_mode, core_userID,
    output core_candidate, phase,
    output cycles_left, results_valid
  );

  modport master (
    output start, req, mode_in,
    output userID_in, candidate_in,
    output core_ready,
    input  grant, core_valid,
    input  core_mode, core_userID,
    input  core_candidate, phase,
    input  cycles_left, results_valid
  );

endinterface

// File: rtl/ballot_terminal_scheduler_rr_arbiter4.sv
// Four-way round-robin pick: first requester at or after ptr_i.
// Ports: req_i, ptr_i in; gnt_o one-hot, idx_o winner, any_o.
module rr_arbiter4 (
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [3:0] gnt_o,
  output logic [1:0] idx_o,
  output logic       any_o
);

  logic       found;
  logic [1:0] cand;

  always_comb begin
    found = 1'b0;
    cand  = '0;
    idx_o = '0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_i + 2'(k);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = cand;
      end
    end
    gnt_o = found ? (4'b0001 << idx_o) : 4'b0000;
    any_o = |req_i;
  end

endmodule

// File: rtl/ballot_terminal_scheduler.sv
// Election phase sequencer plus round-robin sharing of the core port.
// Ports: CLK, RST (async, high), bus (slave side of the scheduler if).
module ballot_terminal_scheduler
  import election_pkg::*;
#(
  parameter int N_TERM      = 4,
  parameter int REG_CYCLES  = 100,
  parameter int VOTE_CYCLES = 100
) (
  input  logic CLK,
  input  logic RST,
  ballot_terminal_scheduler_if.slave bus
);

  phase_t             phase_q;
  logic [TIMER_W-1:0] cyc_q;
  logic [3:0]         grant_q;
  logic               valid_q;
  txn_t               txn_q;
  logic               rv_q;
  logic [1:0]         ptr_q;

  logic [N_TERM-1:0]  elig;
  logic [3:0]         win_gnt;
  logic [1:0]         win_idx;
  logic               win_any;
  logic               slot_free;
  logic               open_ph;
  logic               capture;
  txn_t               txn_d;

  // a terminal still showing req while its grant is up is masked,
  // so a late req drop cannot be captured twice
  assign elig      = bus.req & ~grant_q;
  assign slot_free = !valid_q || bus.core_ready;
  assign open_ph   = (phase_q == PH_REGISTER) ||
                     (phase_q == PH_VOTING);
  assign capture   = open_ph && slot_free && win_any;

  rr_arbiter4 u_arb (
    .req_i (elig),
    .ptr_i (ptr_q),
    .gnt_o (win_gnt),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  always_comb begin
    txn_d = '0;
    unique case (win_idx)
      2'd0: txn_d = '{
        mode:    bus.mode_in[1:0],
        user_id: bus.userID_in[5:0],
        cand:    bus.candidate_in[1:0]
      };
      2'd1: txn_d = '{
        mode:    bus.mode_in[3:2],
        user_id: bus.userID_in[11:6],
        cand:    bus.candidate_in[3:2]
      };
      2'd2: txn_d = '{
        mode:    bus.mode_in[5:4],
        user_id: bus.userID_in[17:12],
        cand:    bus.candidate_in[5:4]
      };
      2'd3: txn_d = '{
        mode:    bus.mode_in[7:6],
        user_id: bus.userID_in[23:18],
        cand:    bus.candidate_in[7:6]
      };
      default: txn_d = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      phase_q <= PH_IDLE;
      cyc_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      txn_q   <= '0;
      rv_q    <= 1'b0;
      ptr_q   <= '0;
    end else begin
      unique case (phase_q)
        PH_IDLE: begin
          if (bus.start) begin
            phase_q <= PH_REGISTER;
            cyc_q   <= TIMER_W'(REG_CYCLES - 1);
          end
        end
        PH_REGISTER: begin
          if (cyc_q == '0) begin
            phase_q <= PH_VOTING;
            cyc_q   <= TIMER_W'(VOTE_CYCLES - 1);
          end else begin
            cyc_q <= cyc_q - 8'd1;
          end
        end
        PH_VOTING: begin
          if (cyc_q == '0) begin
            phase_q <= PH_RESULTS;
            cyc_q   <= '0;
          end else begin
            cyc_q <= cyc_q - 8'd1;
          end
        end
        PH_RESULTS: begin
          // results are final once nothing is left in the slot
          if (slot_free) rv_q <= 1'b1;
        end
        default: phase_q <= PH_IDLE;
      endcase

      if (capture) begin
        valid_q <= 1'b1;
        txn_q   <= txn_d;
        grant_q <= win_gnt;
        ptr_q   <= ptr_after(win_idx);
      end else begin
        grant_q <= '0;
        if (slot_free) valid_q <= 1'b0;
      end
    end
  end

  assign bus.grant          = grant_q;
  assign bus.core_valid     = valid_q;
  assign bus.core_mode      = txn_q.mode;
  assign bus.core_userID    = txn_q.user_id;
  assign bus.core_candidate = txn_q.cand;
  assign bus.phase          = phase_q;
  assign bus.cycles_left    = cyc_q;
  assign bus.results_valid  = rv_q;

endmodule

// File: tb/tb_ballot_terminal_scheduler.sv
// Random + directed bench for ballot_terminal_scheduler with an
// elapsed-time election model and a transaction scoreboard.
module tb_ballot_terminal_scheduler;
  import election_pkg::*;

  localparam int REG  = 100;
  localparam int VOTE = 100;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  ballot_terminal_scheduler_if bus();

  ballot_terminal_scheduler #(
    .N_TERM      (4),
    .REG_CYCLES  (REG),
    .VOTE_CYCLES (VOTE)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // reference model: election time as elapsed cycles since start
  bit         m_started = 0;
  int         m_e = 0;
  bit         m_valid = 0;
  logic [3:0] m_grant = '0;
  int         m_ptr = 0;
  bit         m_rv = 0;
  logic [9:0] exp_q[$];

  // terminal agents
  bit         pend[4];
  bit         slow[4];
  bit         hold1[4];
  logic [1:0] t_mode[4];
  logic [5:0] t_uid[4];
  logic [1:0] t_cand[4];

  int req_pct   = 0;
  int rdy_pct   = 100;
  int force_rdy = -1;
  bit start_n   = 0;
  bit end_hook  = 0;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int m_ph();
    if (!m_started) return 0;
    if (m_e < REG) return 1;
    if (m_e < REG + VOTE) return 2;
    return 3;
  endfunction

  function automatic int m_cl();
    case (m_ph())
      1: return REG - 1 - m_e;
      2: return REG + VOTE - 1 - m_e;
      default: return 0;
    endcase
  endfunction

  // one clock edge of the election rules, using the inputs
  // that were on the bus at that edge
  task automatic model_edge();
    int ph;
    int w;
    bit free;
    logic [3:0] elig;
    ph   = m_ph();
    free = !m_valid || bus.core_ready;
    elig = bus.req & ~m_grant;
    if ((ph == 1 || ph == 2) && free && elig != 0) begin
      w = -1;
      for (int k = 0; k < 4; k++)
        if (w < 0 && elig[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
      exp_q.push_back({bus.mode_in[2*w +: 2],
                       bus.userID_in[6*w +: 6],
                       bus.candidate_in[2*w +: 2]});
      m_valid = 1;
      m_grant = 4'b0001 << w;
      m_ptr   = (w + 1) % 4;
    end else begin
      if (free) m_valid = 0;
      m_grant = '0;
    end
    if (ph == 3 && free) m_rv = 1;
    if (!m_started) begin
      if (bus.start) begin
        m_started = 1;
        m_e = 0;
      end
    end else begin
      m_e++;
    end
  endtask

  task automatic new_req(int t);
    pend[t]   = 1;
    hold1[t]  = 0;
    t_mode[t] = 2'($urandom_range(3));
    t_uid[t]  = 6'($urandom_range(63));
    t_cand[t] = 2'($urandom_range(3));
    slow[t]   = (t == 2) ? 1'b1 : 1'($urandom_range(1));
  endtask

  task automatic terminals_update();
    for (int t = 0; t < 4; t++) begin
      if (m_grant[t]) begin
        if (slow[t]) hold1[t] = 1;
        else pend[t] = 0;
      end else if (hold1[t]) begin
        hold1[t] = 0;
        pend[t]  = 0;
      end else if (!pend[t] &&
                   $urandom_range(99) < req_pct) begin
        new_req(t);
      end
    end
  endtask

  task automatic drive();
    logic [3:0]  r;
    logic [7:0]  md;
    logic [7:0]  cd;
    logic [23:0] ud;
    for (int t = 0; t < 4; t++) begin
      r[t]         = pend[t];
      md[2*t +: 2] = t_mode[t];
      ud[6*t +: 6] = t_uid[t];
      cd[2*t +: 2] = t_cand[t];
    end
    bus.req          = r;
    bus.mode_in      = md;
    bus.userID_in    = ud;
    bus.candidate_in = cd;
    bus.start = start_n ||
                (m_started && $urandom_range(9) == 0);
    if (force_rdy >= 0) bus.core_ready = force_rdy[0];
    else bus.core_ready = ($urandom_range(99) < rdy_pct);
    start_n = 0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    if (!RST) model_edge();
    terminals_update();
    if (end_hook && m_ph() == 2 && m_cl() == 0) begin
      end_hook = 0;
      if (!pend[0]) new_req(0);
      force_rdy = 0;
    end
    drive();
  endtask

  task automatic async_reset();
    @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk("rst_phase", int'(bus.phase), 0);
    chk("rst_cycles_left", int'(bus.cycles_left), 0);
    chk("rst_grant", int'(bus.grant), 0);
    chk("rst_core_valid", int'(bus.core_valid), 0);
    chk("rst_payload", int'({bus.core_mode, bus.core_userID,
                             bus.core_candidate}), 0);
    chk("rst_results_valid", int'(bus.results_valid), 0);
    m_started = 0;
    m_e       = 0;
    m_valid   = 0;
    m_grant   = '0;
    m_ptr     = 0;
    m_rv      = 0;
    exp_q.delete();
    for (int t = 0; t < 4; t++) begin
      pend[t]  = 0;
      hold1[t] = 0;
    end
    req_pct   = 0;
    force_rdy = -1;
    drive();
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  // monitor: cycle-level outputs and accepted core transactions
  always @(negedge CLK) begin
    chk("phase", int'(bus.phase), m_ph());
    chk("cycles_left", int'(bus.cycles_left), m_cl());
    chk("grant", int'(bus.grant), int'(m_grant));
    chk("core_valid", int'(bus.core_valid), int'(m_valid));
    chk("results_valid", int'(bus.results_valid), int'(m_rv));
    if (bus.core_valid && bus.core_ready) begin
      if (exp_q.size() == 0)
        chk("unexpected_txn", 1, 0);
      else
        chk("payload", int'({bus.core_mode, bus.core_userID,
                             bus.core_candidate}),
            int'(exp_q.pop_front()));
    end
  end

  initial begin
    int n;
    for (int t = 0; t < 4; t++) begin
      pend[t]   = 0;
      hold1[t]  = 0;
      slow[t]   = (t == 2);
      t_mode[t] = '0;
      t_uid[t]  = '0;
      t_cand[t] = '0;
    end
    drive();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    chk("init_payload", int'({bus.core_mode, bus.core_userID,
                              bus.core_candidate}), 0);
    chk("init_phase", int'(bus.phase), 0);

    // idle, then start
    repeat (3) step();
    start_n = 1;
    step();
    step();

    // all four terminals at once, core always ready
    for (int t = 0; t < 4; t++) new_req(t);
    force_rdy = 1;
    repeat (9) step();

    // core stalls with two requests waiting
    new_req(0);
    new_req(1);
    force_rdy = 0;
    repeat (5) step();
    force_rdy = 1;
    repeat (4) step();

    // random traffic through REGISTER into late VOTING
    force_rdy = -1;
    req_pct   = 35;
    rdy_pct   = 60;
    n = 0;
    while (!(m_ph() == 2 && m_cl() <= 12) && n < 400) begin
      step();
      n++;
    end
    if (!(m_ph() == 2 && m_cl() <= 12))
      chk("timeout_late_voting", 0, 1);

    // drain, then capture on the last VOTING cycle
    req_pct   = 0;
    force_rdy = 1;
    end_hook  = 1;
    n = 0;
    while (end_hook && n < 40) begin
      step();
      n++;
    end
    if (end_hook) chk("timeout_last_cycle", 0, 1);
    repeat (4) step();
    force_rdy = 1;
    repeat (4) step();
    force_rdy = -1;

    // second election, reset mid-VOTING with a pending txn
    async_reset();
    start_n = 1;
    step();
    req_pct = 50;
    rdy_pct = 30;
    n = 0;
    while (!(m_ph() == 2 && m_e >= 150 && m_valid) &&
           n < 400) begin
      step();
      n++;
    end
    if (!(m_ph() == 2 && m_valid))
      chk("timeout_mid_voting", 0, 1);
    async_reset();

    // start is required again; then a full random election
    repeat (5) step();
    start_n = 1;
    step();
    req_pct = 30;
    rdy_pct = 70;
    repeat (215) step();
    force_rdy = 1;
    repeat (3) step();

    chk("final_phase", int'(bus.phase), 3);
    chk("final_results_valid", int'(bus.results_valid), 1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
